regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the MIPS core; next generation of the 2R/1W RegFile.

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports, optional
// hardwired zero register and a sequenced clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = we0 && !clr_busy && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !clr_busy && !((ZERO_REG != 0) && (wa1 == '0));

  // Port 1 is assigned after port 0 so it wins on an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem      <= '{default: '0};
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr0_ok) mem[wa0] <= wd0;
          if (wr1_ok) mem[wa1] <= wd1;
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state    <= DONE;
            clr_done <= 1'b1;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
          clr_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (!clr_busy) begin
        if (wr0_ok && (wa0 == addr)) val = wd0;
        if (wr1_ok && (wa1 == addr)) val = wd1;
      end
`endif
      // Reset is tested explicitly so forwarded write data cannot leak out during reset.
      if (reset || ((ZERO_REG != 0) && (addr == '0))) val = '0;
    end

    assign rd[g*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters): directed vector table, randomised
// traffic against an array model, and clear/reset sequences. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  logic [4:0]  ra0, ra1;
  logic [31:0] rd0, rd1;
  assign ra  = {ra1, ra0};
  assign rd0 = rd[31:0];
  assign rd1 = rd[63:32];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] model [32];

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference semantics: register 0 is always zero; port 1 overrides port 0 on the same address.
  task automatic model_commit();
    if (we0 && wa0 != 5'd0) model[wa0] = wd0;
    if (we1 && wa1 != 5'd0) model[wa1] = wd1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic busy);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (!busy) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
`endif
    return busy ? model[a] : model[a];
  endfunction

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic check_all_zero(input string name);
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      #1;
      chk(name, rd0, 32'd0);
      chk(name, rd1, 32'd0);
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned dones;
    int unsigned busy_seen;

    reset = 1'b1; clr_req = 1'b0; ra0 = '0; ra1 = '0;
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = '0;

    #2;
    ra0 = 5'd5; ra1 = 5'd31;
    #1;
    chk("reset_rd0", rd0, 32'd0);
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_busy", {31'd0, clr_busy}, 32'd0);
    chk("reset_done", {31'd0, clr_done}, 32'd0);
    tick();
    reset = 1'b0;

    // Directed vectors; expectations are for reads on the cycle after each write.
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,        5'd5,  5'd0, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 5'd0, 32'h0,        5'd0,  5'd5, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd7,  32'h0000_1111, 1'b1, 5'd7, 32'h0000_2222, 5'd7,  5'd5, 32'h0000_2222, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd8,  32'h0000_1111, 1'b1, 5'd7, 32'h0000_2222, 5'd8,  5'd7, 32'h0000_1111, 32'h0000_2222};
    vecs[4] = '{1'b1, 5'd9,  32'h0000_9999, 1'b1, 5'd0, 32'h0000_FFFF, 5'd0,  5'd9, 32'h0,         32'h0000_9999};
    vecs[5] = '{1'b1, 5'd31, 32'h3131_3131, 1'b0, 5'd4, 32'h0000_4444, 5'd31, 5'd8, 32'h3131_3131, 32'h0000_1111};

    for (int i = 0; i < 6; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      model_commit();
      tick();
      idle_inputs();
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #1;
      chk($sformatf("vec%0d_rd0", i), rd0, vecs[i].exp0);
      chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
    end

    // Same-cycle write/read on one address: forwarded or old value.
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_0042; ra0 = 5'd3; ra1 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd0, 32'h0000_0042);
`else
    chk("bypass_same_cycle", rd0, 32'h0);
`endif
    model_commit();
    tick();
    idle_inputs();
    #1;
    chk("bypass_next_cycle", rd0, 32'h0000_0042);

    // Randomised traffic with a bias towards colliding addresses.
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      ra0 = ($urandom_range(0, 1) != 0) ? wa0 : 5'($urandom);
      ra1 = ($urandom_range(0, 1) != 0) ? wa1 : 5'($urandom);
      #2;
      chk("rand_rd0", rd0, model_read(ra0, 1'b0));
      chk("rand_rd1", rd1, model_read(ra1, 1'b0));
      model_commit();
      tick();
    end
    idle_inputs();

    // Fill every register, then run a full clear.
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; wa0 = 5'(2 * i);     wd0 = 32'hA5A5_A5A5;
      we1 = 1'b1; wa1 = 5'(2 * i + 1); wd1 = 32'hA5A5_A5A5;
      model_commit();
      tick();
    end
    idle_inputs();
    ra0 = 5'd17; ra1 = 5'd0;
    #1;
    chk("fill_rd0", rd0, 32'hA5A5_A5A5);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0; dones = 0;
    while (clr_busy && n < 100) begin
      if (clr_done) dones++;
      if (n == 10) begin
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h1234_5678;
        ra0 = 5'd2; ra1 = 5'd31;
        #1;
        chk("mid_clear_no_fwd", rd0, 32'd0);
        chk("mid_clear_partial", rd1, model[31]);
      end
      tick();
      we1 = 1'b0;
      n++;
    end
    chk("clear_timeout", {31'd0, n < 100}, 32'd1);
    chk("clear_busy_cycles", n, 32'd33);
    chk("clear_done_pulses", dones, 32'd1);
    for (int i = 0; i < 32; i++) model[i] = '0;
    check_all_zero("after_clear");

    // clr_req held: one IDLE cycle after DONE, then a fresh clear.
    clr_req = 1'b1;
    tick();
    n = 0;
    while (!clr_done && n < 100) begin
      tick();
      n++;
    end
    chk("held_done_timeout", {31'd0, n < 100}, 32'd1);
    tick();
    chk("held_idle_gap", {31'd0, clr_busy}, 32'd0);
    tick();
    chk("held_restart", {31'd0, clr_busy}, 32'd1);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      tick();
      n++;
    end
    chk("held_finish_timeout", {31'd0, n < 100}, 32'd1);

    // Reset during the 10th CLEAR cycle aborts the clear.
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h2020_2020;
    we1 = 1'b1; wa1 = 5'd4;  wd1 = 32'h0000_0044;
    tick();
    idle_inputs();
    ra0 = 5'd20; ra1 = 5'd4;
    #1;
    chk("pre_abort_rd0", rd0, 32'h2020_2020);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      if (clr_done) dones++;
      tick();
    end
    chk("pre_abort_rd0_kept", rd0, 32'h2020_2020);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_rd0", rd0, 32'd0);
    chk("abort_busy", {31'd0, clr_busy}, 32'd0);
    tick();
    reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_done) dones++;
      if (clr_busy) busy_seen++;
      tick();
    end
    chk("abort_no_done", dones, 32'd0);
    chk("abort_idle", busy_seen, 32'd0);
    check_all_zero("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
